// File: rtl/sdram_block_responder.sv
// Behavioural SDRAM responder for cache block transfers: edge-detected strobes,
// in-order burst checking with idle timeout, one-cycle read latency.
module sdram_block_responder #(
   parameter int BLOCKSIZE_W = 5,
   parameter int ADDR_W      = 3,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT     = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_W-1:0]      blk_addr,
   input  logic [BLOCKSIZE_W-1:0] addr_offset,
   input  logic                   memstrb,
   input  logic                   wr_rd_sdram,
   input  logic [DATA_W-1:0]      din,
   input  logic                   err_clr,
   output logic [DATA_W-1:0]      dout,
   output logic                   dout_vld,
   output logic                   burst_done,
   output logic                   burst_err,
   output logic                   busy
);

   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam int AW     = ADDR_W + BLOCKSIZE_W;
   localparam int MEM_D  = 2 ** AW;

   typedef enum logic [1:0] {IDLE = 2'd0, WR_BURST = 2'd1, RD_BURST = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic                   memstrb_q;
   logic [ADDR_W-1:0]      blk_q, blk_d;
   logic                   wr_q, wr_d;
   logic [BLOCKSIZE_W-1:0] exp_off_q, exp_off_d;
   logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic [DATA_W-1:0]      dout_q, dout_d;
   logic                   dout_vld_q, dout_vld_d;
   logic                   burst_done_q, burst_done_d;
   logic                   burst_err_q, burst_err_d;
   logic [DATA_W-1:0]      mem_q [MEM_D];

   logic                   stb;
   logic                   access;
   logic                   err_set;
   logic                   in_order;
   logic [AW-1:0]          mem_addr;

   assign stb      = memstrb & ~memstrb_q;
   assign mem_addr = {blk_addr, addr_offset};
   assign in_order = (addr_offset == exp_off_q) && (blk_addr == blk_q) && (wr_rd_sdram == wr_q);

   always_comb begin
      state_d      = state_q;
      blk_d        = blk_q;
      wr_d         = wr_q;
      exp_off_d    = exp_off_q;
      tmo_cnt_d    = '0;
      access       = 1'b0;
      err_set      = 1'b0;
      burst_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (stb) begin
               if (addr_offset == '0) begin
                  access    = 1'b1;
                  blk_d     = blk_addr;
                  wr_d      = wr_rd_sdram;
                  exp_off_d = BLOCKSIZE_W'(1);
                  state_d   = wr_rd_sdram ? WR_BURST : RD_BURST;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         default: begin
            if (stb) begin
               if (in_order) begin
                  access    = 1'b1;
                  exp_off_d = exp_off_q + BLOCKSIZE_W'(1);
                  if (&addr_offset) begin
                     burst_done_d = 1'b1;
                     state_d      = IDLE;
                  end
               end else begin
                  // A mis-ordered strobe only closes the burst; it never opens a new one.
                  err_set = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
                  err_set   = 1'b1;
                  state_d   = IDLE;
                  tmo_cnt_d = '0;
               end
            end
         end
      endcase

      dout_vld_d  = access & ~wr_rd_sdram;
      dout_d      = dout_vld_d ? mem_q[mem_addr] : dout_q;
      burst_err_d = err_set | (burst_err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         memstrb_q    <= 1'b0;
         blk_q        <= '0;
         wr_q         <= 1'b0;
         exp_off_q    <= '0;
         tmo_cnt_q    <= '0;
         dout_q       <= '0;
         dout_vld_q   <= 1'b0;
         burst_done_q <= 1'b0;
         burst_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         memstrb_q    <= memstrb;
         blk_q        <= blk_d;
         wr_q         <= wr_d;
         exp_off_q    <= exp_off_d;
         tmo_cnt_q    <= tmo_cnt_d;
         dout_q       <= dout_d;
         dout_vld_q   <= dout_vld_d;
         burst_done_q <= burst_done_d;
         burst_err_q  <= burst_err_d;
      end
   end

   // Storage is deliberately outside the reset domain so data survives a reset.
   always_ff @(posedge clk) begin
      if (access && wr_rd_sdram) begin
         mem_q[mem_addr] <= din;
      end
   end

   assign dout       = dout_q;
   assign dout_vld   = dout_vld_q;
   assign burst_done = burst_done_q;
   assign burst_err  = burst_err_q;
   assign busy       = (state_q != IDLE);

endmodule
